// File: rtl/traffic_density_classifier.sv
// traffic_density_classifier
// Counts vehicle pixels inside the ROI per frame and sums them over a window
// of N_FRAMES frames. Each finished window is classified as LOW/MID/HIGH with
// downward hysteresis. The level drives traffic_sel and the matching
// red/green durations. o_sel_pending stays high until the light FSM has
// sampled a changed selection.
module traffic_density_classifier #(
  parameter int          CNT_W      = 19,
  parameter int          N_FRAMES   = 4,
  parameter int          TH_LOW     = 2000,
  parameter int          TH_HIGH    = 8000,
  parameter int          HYST       = 500,
  parameter logic [4:0]  RED_LOW    = 5'd5,
  parameter logic [4:0]  GREEN_LOW  = 5'd10,
  parameter logic [4:0]  RED_MID    = 5'd8,
  parameter logic [4:0]  GREEN_MID  = 5'd8,
  parameter logic [4:0]  RED_HIGH   = 5'd12,
  parameter logic [4:0]  GREEN_HIGH = 5'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_pix_valid,
  input  logic       i_pix_car,
  input  logic       i_frame_end,
  input  logic       tr_valid,
  output logic [1:0] traffic_sel,
  output logic [4:0] howmany_count_red,
  output logic [4:0] howmany_count_green,
  output logic       o_upd,
  output logic       o_sel_pending
);

  // The window sum holds N_FRAMES saturated frame counts plus one spare bit,
  // so it cannot wrap.
  localparam int SUM_W = CNT_W + $clog2(N_FRAMES) + 1;
  localparam int IDX_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAMES - 1);
  localparam logic [SUM_W-1:0] TH_HIGH_UP = SUM_W'(TH_HIGH);
  localparam logic [SUM_W-1:0] TH_LOW_UP  = SUM_W'(TH_LOW);
  localparam logic [SUM_W-1:0] TH_HIGH_DN = SUM_W'(TH_HIGH - HYST);
  localparam logic [SUM_W-1:0] TH_LOW_DN  = SUM_W'(TH_LOW - HYST);

  localparam logic [1:0] LVL_LOW  = 2'b00;
  localparam logic [1:0] LVL_MID  = 2'b01;
  localparam logic [1:0] LVL_HIGH = 2'b10;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   frame_cnt_reg;
  logic [IDX_W-1:0]   frame_idx_reg;
  logic [SUM_W-1:0]   win_sum_reg;
  logic [SUM_W-1:0]   eval_sum_reg;
  logic               eval_req_reg;
  logic [1:0]         new_level_reg;
  logic [1:0]         traffic_sel_reg;
  logic [4:0]         red_reg, green_reg;
  logic               upd_reg;
  logic               sel_changed_reg;
  logic               pending_reg;

  logic [CNT_W-1:0]   frame_total;
  logic [SUM_W-1:0]   window_total;
  logic               window_done;
  logic [1:0]         raw_level, low_level, eval_level;
  logic [4:0]         red_next, green_next;
  logic               sel_differs;

  function automatic logic [1:0] classify(input logic [SUM_W-1:0] sum,
                                          input logic [SUM_W-1:0] th_hi,
                                          input logic [SUM_W-1:0] th_lo);
    if (sum >= th_hi)      return LVL_HIGH;
    else if (sum >= th_lo) return LVL_MID;
    else                   return LVL_LOW;
  endfunction

  // Frame count including the current pixel, so a car pixel on the
  // frame_end cycle lands in the frame that is ending.
  always_comb begin
    frame_total = frame_cnt_reg;
    if (i_pix_valid && i_pix_car && (frame_cnt_reg != '1))
      frame_total = frame_cnt_reg + CNT_W'(1);
    window_total = win_sum_reg + SUM_W'(frame_total);
    window_done  = i_frame_end && (frame_idx_reg == LAST_IDX);
  end

  // Pixel counting and window accumulation run regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      frame_idx_reg <= '0;
      win_sum_reg   <= '0;
      eval_sum_reg  <= '0;
    end else if (i_frame_end) begin
      frame_cnt_reg <= '0;
      if (window_done) begin
        eval_sum_reg  <= window_total;
        win_sum_reg   <= '0;
        frame_idx_reg <= '0;
      end else begin
        win_sum_reg   <= window_total;
        frame_idx_reg <= frame_idx_reg + IDX_W'(1);
      end
    end else begin
      frame_cnt_reg <= frame_total;
    end
  end

  // A window closing during EVAL is remembered so UPDATE re-enters EVAL.
  always_ff @(posedge clk) begin
    if (reset)
      eval_req_reg <= 1'b0;
    else if ((state_reg == EVAL) && window_done)
      eval_req_reg <= 1'b1;
    else if (state_reg == UPDATE)
      eval_req_reg <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ACCUM;
    else       state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (window_done) state_next = EVAL;
      EVAL:    state_next = UPDATE;
      UPDATE:  state_next = (window_done || eval_req_reg) ? EVAL : ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Going up uses the plain thresholds; going down must also clear the
  // lowered thresholds, which may drop one or two levels at once.
  always_comb begin
    raw_level  = classify(eval_sum_reg, TH_HIGH_UP, TH_LOW_UP);
    low_level  = classify(eval_sum_reg, TH_HIGH_DN, TH_LOW_DN);
    eval_level = (raw_level >= traffic_sel_reg) ? raw_level : low_level;
  end

  // Level decided in EVAL, published in UPDATE.
  always_ff @(posedge clk) begin
    if (reset)                  new_level_reg <= LVL_LOW;
    else if (state_reg == EVAL) new_level_reg <= eval_level;
  end

  // Duration table lookup for the level about to be published.
  always_comb begin
    red_next   = RED_LOW;
    green_next = GREEN_LOW;
    case (new_level_reg)
      LVL_MID:  begin red_next = RED_MID;  green_next = GREEN_MID;  end
      LVL_HIGH: begin red_next = RED_HIGH; green_next = GREEN_HIGH; end
      default:  begin red_next = RED_LOW;  green_next = GREEN_LOW;  end
    endcase
    sel_differs = (new_level_reg != traffic_sel_reg);
  end

  // Selection and durations change together, only at the UPDATE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      traffic_sel_reg <= LVL_LOW;
      red_reg         <= RED_LOW;
      green_reg       <= GREEN_LOW;
      upd_reg         <= 1'b0;
      sel_changed_reg <= 1'b0;
    end else begin
      upd_reg         <= (state_reg == UPDATE);
      sel_changed_reg <= (state_reg == UPDATE) && sel_differs;
      if (state_reg == UPDATE) begin
        traffic_sel_reg <= new_level_reg;
        red_reg         <= red_next;
        green_reg       <= green_next;
      end
    end
  end

  // Pending flag: a tr_valid right after a change sampled the old
  // selection, so it does not clear the flag; a new change always sets it.
  always_ff @(posedge clk) begin
    if (reset)
      pending_reg <= 1'b0;
    else if ((state_reg == UPDATE) && sel_differs)
      pending_reg <= 1'b1;
    else if (tr_valid && !sel_changed_reg)
      pending_reg <= 1'b0;
  end

  assign traffic_sel         = traffic_sel_reg;
  assign howmany_count_red   = red_reg;
  assign howmany_count_green = green_reg;
  assign o_upd               = upd_reg;
  assign o_sel_pending       = pending_reg;

endmodule

// File: tb/tb_traffic_density_classifier.sv
// Bench for traffic_density_classifier: directed windows push expected
// results into a scoreboard; a monitor checks each o_upd against it.
module tb_traffic_density_classifier;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_pix_valid = 1'b0;
  logic       i_pix_car = 1'b0;
  logic       i_frame_end = 1'b0;
  logic       tr_valid = 1'b0;
  logic [1:0] traffic_sel;
  logic [4:0] howmany_count_red;
  logic [4:0] howmany_count_green;
  logic       o_upd;
  logic       o_sel_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] red;
    logic [4:0] green;
    logic       pend;
    int         upd_cyc;
  } exp_t;

  exp_t sb_q[$];

  traffic_density_classifier #(
    .CNT_W(9), .N_FRAMES(2), .TH_LOW(100), .TH_HIGH(300), .HYST(20)
  ) dut (
    .clk(clk), .reset(reset),
    .i_pix_valid(i_pix_valid), .i_pix_car(i_pix_car), .i_frame_end(i_frame_end),
    .tr_valid(tr_valid),
    .traffic_sel(traffic_sel),
    .howmany_count_red(howmany_count_red),
    .howmany_count_green(howmany_count_green),
    .o_upd(o_upd), .o_sel_pending(o_sel_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] red_of(input logic [1:0] s);
    case (s)
      2'b01:   return 5'd8;
      2'b10:   return 5'd12;
      default: return 5'd5;
    endcase
  endfunction

  function automatic logic [4:0] green_of(input logic [1:0] s);
    case (s)
      2'b01:   return 5'd8;
      2'b10:   return 5'd4;
      default: return 5'd10;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n counted pixels, two non-counted noise pixels, then frame_end.
  // With car_on_end the last counted pixel shares the frame_end cycle.
  task automatic drive_frame(input int n, input bit car_on_end);
    int body;
    body = car_on_end ? n - 1 : n;
    for (int i = 0; i < body; i++) begin
      i_pix_valid = 1'b1; i_pix_car = 1'b1; tick();
    end
    i_pix_valid = 1'b1; i_pix_car = 1'b0; tick();
    i_pix_valid = 1'b0; i_pix_car = 1'b1; tick();
    i_pix_valid = car_on_end; i_pix_car = car_on_end; i_frame_end = 1'b1; tick();
    i_pix_valid = 1'b0; i_pix_car = 1'b0; i_frame_end = 1'b0;
  endtask

  // Two-frame window; returns just after the closing frame_end edge.
  task automatic run_window(input int a, input int b, input bit car_on_end,
                            input logic [1:0] exp_sel, input logic exp_pend);
    exp_t e;
    drive_frame(a, car_on_end);
    drive_frame(b, 1'b0);
    e.sel = exp_sel; e.red = red_of(exp_sel); e.green = green_of(exp_sel);
    e.pend = exp_pend; e.upd_cyc = cyc + 2;
    sb_q.push_back(e);
    $display("window %0d+%0d pushed: sel=%0d pend=%0d due cycle %0d",
             a, b, exp_sel, exp_pend, e.upd_cyc);
  endtask

  // Monitor: scoreboard comparison on each o_upd, stability otherwise.
  logic [11:0] prev_out;
  logic        reset_d = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (o_upd) begin
      if (sb_q.size() == 0) begin
        check("unexpected_upd", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("upd_cycle", cyc, e.upd_cyc);
        check("upd_sel", int'(traffic_sel), int'(e.sel));
        check("upd_red", int'(howmany_count_red), int'(e.red));
        check("upd_green", int'(howmany_count_green), int'(e.green));
        check("upd_pend", int'(o_sel_pending), int'(e.pend));
        $display("update at cycle %0d: sel=%0d red=%0d green=%0d pend=%0d",
                 cyc, traffic_sel, howmany_count_red, howmany_count_green, o_sel_pending);
      end
    end else if (!reset && !reset_d) begin
      check("outputs_stable", int'({traffic_sel, howmany_count_red, howmany_count_green}),
            int'(prev_out));
    end
    prev_out = {traffic_sel, howmany_count_red, howmany_count_green};
    reset_d  = reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_sel", int'(traffic_sel), 0);
    check("rst_red", int'(howmany_count_red), 5);
    check("rst_green", int'(howmany_count_green), 10);
    check("rst_pend", int'(o_sel_pending), 0);
    check("rst_upd", int'(o_upd), 0);
    tick();

    // 120 -> MID; tr_valid one cycle after the change must not clear.
    run_window(60, 60, 1'b0, 2'b01, 1'b1);
    tick(); tick();
    tr_valid = 1'b1; tick(); tr_valid = 1'b0;
    check("pend_tr_immediate", int'(o_sel_pending), 1);
    repeat (3) tick();
    tr_valid = 1'b1; tick(); tr_valid = 1'b0;
    check("pend_tr_later", int'(o_sel_pending), 0);
    repeat (2) tick();

    // 90 stays MID through hysteresis; pending untouched (0).
    run_window(45, 45, 1'b0, 2'b01, 1'b0);
    repeat (4) tick();

    // 70 -> LOW; tr_valid 5 cycles after the change clears.
    run_window(35, 35, 1'b0, 2'b00, 1'b1);
    tick(); tick();
    repeat (4) tick();
    tr_valid = 1'b1; tick(); tr_valid = 1'b0;
    check("pend_tr_5cyc", int'(o_sel_pending), 0);
    tick();

    // 400 -> HIGH, then 60 -> LOW directly (double step).
    run_window(200, 200, 1'b0, 2'b10, 1'b1);
    repeat (4) tick();
    run_window(30, 30, 1'b0, 2'b00, 1'b1);
    repeat (4) tick();

    // 517 pixels saturate at 511 -> HIGH (a wrap would give 5 -> LOW).
    run_window(517, 0, 1'b0, 2'b10, 1'b1);
    repeat (4) tick();
    run_window(0, 0, 1'b0, 2'b00, 1'b1);
    repeat (4) tick();

    // Sum exactly TH_LOW, last pixel of frame 1 on its frame_end -> MID.
    run_window(50, 50, 1'b1, 2'b01, 1'b1);
    repeat (4) tick();

    // Reset after frame 1 of 2 discards the partial 250.
    drive_frame(250, 1'b0);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    check("rst2_sel", int'(traffic_sel), 0);
    check("rst2_red", int'(howmany_count_red), 5);
    check("rst2_green", int'(howmany_count_green), 10);
    check("rst2_pend", int'(o_sel_pending), 0);
    tick();
    run_window(60, 50, 1'b0, 2'b01, 1'b1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_density_classifier.md
Name: traffic_density_classifier

Overview:
- Producer side of the traffic-light controller's selection interface.
- Counts vehicle-occupied pixels inside the camera ROI per VGA frame and sums them over a window of N_FRAMES frames.
- Classifies the window sum into LOW / MID / HIGH density with hysteresis, then drives traffic_sel and the matching red/green durations.
- Tracks whether the light FSM has taken the latest selection, using its tr_valid pulse.

Parameters:
- CNT_W, 19: per-frame pixel counter width. Counter saturates at 2^CNT_W-1.
- N_FRAMES, 4: frames per classification window. Must be ≥1.
- TH_LOW, 2000: window sum at or above which density is at least MID.
- TH_HIGH, 8000: window sum at or above which density is HIGH.
- HYST, 500: downward hysteresis margin. Constraints: HYST < TH_LOW and TH_LOW < TH_HIGH-HYST.
- RED_LOW/GREEN_LOW, 5/10: durations for level 00, in seconds.
- RED_MID/GREEN_MID, 8/8: durations for level 01, in seconds.
- RED_HIGH/GREEN_HIGH, 12/4: durations for level 10, in seconds.
- All six duration parameters are 5-bit values.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_pix_valid  in  1  current pixel lies inside the ROI
- i_pix_car  in  1  current pixel is classified as vehicle; counted only when i_pix_valid=1
- i_frame_end  in  1  single-cycle pulse marking the last pixel of a frame
- tr_valid  in  1  pulse from the light FSM after it samples traffic_sel
- traffic_sel  out  2  density level: 00 LOW, 01 MID, 10 HIGH. Value 11 is never driven.
- howmany_count_red  out  5  red duration for the current traffic_sel
- howmany_count_green  out  5  green duration for the current traffic_sel
- o_upd  out  1  one-cycle pulse in the cycle following each classification write
- o_sel_pending  out  1  traffic_sel changed and the light FSM has not yet taken it

Behaviour:
- Reset (sync, active-high):
  - Counters, frame index and window sum clear to 0.
  - State goes to ACCUM.
  - traffic_sel=00, howmany_count_red=RED_LOW, howmany_count_green=GREEN_LOW.
  - o_upd=0, o_sel_pending=0.
  - Reset asserted mid-window discards the partial window.
- Pixel counting:
  - Runs in every state.
  - frame_cnt increments when i_pix_valid and i_pix_car are both 1, saturating at max.
  - When a counted pixel coincides with i_frame_end, that pixel belongs to the ending frame.
- Frame end handling (on i_frame_end):
  - win_sum += frame_cnt (including any same-cycle pixel); frame_cnt clears to 0.
  - win_sum width is CNT_W+$clog2(N_FRAMES)+1 bits, so it never overflows.
  - frame_idx increments.
  - If frame_idx==N_FRAMES-1: snapshot the completed sum into eval_sum, clear win_sum and frame_idx, and enter EVAL. The next window starts accumulating immediately.
- State machine:
  - ACCUM: waits for window completion.
  - EVAL (1 cycle): computes the new level.
    - raw = HIGH if eval_sum≥TH_HIGH; else MID if ≥TH_LOW; else LOW.
    - If raw ≥ current level, the new level is raw.
    - Otherwise the new level is the same comparison with thresholds TH_HIGH-HYST and TH_LOW-HYST. This may step down one or two levels.
  - UPDATE (1 cycle): registers traffic_sel, howmany_count_red and howmany_count_green together from the parameter table, then returns to ACCUM.
    - o_upd is high in the cycle after UPDATE.
    - Outputs change only at this edge; they are stable otherwise.
  - Latency: the outputs change 2 clocks after the i_frame_end that closes the window.
  - A frame_end during EVAL or UPDATE counts toward the new window only. If N_FRAMES=1, that window completes and a second EVAL follows directly after UPDATE.
- o_sel_pending:
  - Set at the UPDATE edge if the new level differs from the previous traffic_sel.
  - Cleared by tr_valid, except when traffic_sel changed at the immediately preceding edge. In that case the FSM sampled the old value, so the flag stays set.
  - If set and clear coincide, set wins.
  - Reclassifying to the same level leaves the flag unchanged.

Test Plan:
- Reset: hold reset 3 cycles, then release → traffic_sel=00, red=5, green=10, o_sel_pending=0, o_upd=0.
- Rising density (N_FRAMES=2, TH_LOW=100, TH_HIGH=300, HYST=20): drive frames of 60+60 car pixels → sel=01, o_upd pulses 2 clocks after the 2nd frame_end, red=8, green=8, pending=1.
- Hysteresis: from sel=01, drive 45+45 (sum 90, ≥80) → sel stays 01, pending unchanged. Then drive 35+35 (sum 70) → sel=00.
- Double step and saturation: from sel=10, drive 30+30 (sum 60 <80) → sel=00 directly. Separately, a frame with 2^CNT_W+5 car pixels → frame count saturates and sel=10.
- Handshake: tr_valid 5 cycles after a change → pending clears. tr_valid exactly 1 cycle after a change → pending stays 1. A later tr_valid → pending clears.
- Edge and reset cases: i_pix_car with i_frame_end in the same cycle → that pixel is counted in the ending frame, verified by a sum exactly at TH_LOW giving sel=01. Reset after frame 1 of 2 → the partial sum is discarded and the next window starts from 0.
